count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_pkg.sv | 18 +
 rtl/sat_counter.sv | 38 +++
 rtl/count_checker.sv | 135 +++++++++++++
 tb/tb_count_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the count-sequence checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package count_pkg;

    // Width of the observed JK up-counter.
    localparam int CNT_W = 3;

    // Consecutive matching samples needed to leave ERROR when resync is built in.
    localparam int RESYNC_RUN = 2;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
// Latency: q reflects an inc one clock after it is sampled.
// Backpressure: none; inc is ignored while saturated, clr wins over inc.
module sat_counter #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [WRAP_W-1:0] q
);

    logic [WRAP_W-1:0] cnt_q;
    logic [WRAP_W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WRAP_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Watches a 3-bit up-counter and flags samples that break y(n) = y(n-1) + w(n-1).
// Latency: all outputs registered, one clock after the offending/wrapping sample.
// Backpressure: none; free-running observer. COUNT_CHECKER_RESYNC_EN allows ERROR->TRACK recovery.
module count_checker
    import count_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              w_in,
    input  logic [CNT_W-1:0]  y_in,
    output logic              locked,
    output logic              err,
    output logic              err_sticky,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_count
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] y_prev_q;
    logic             w_prev_q;
    logic             err_q;
    logic             err_d;
    logic             sticky_q;
    logic             sticky_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             locked_q;

    logic [CNT_W-1:0] exp_val;
    logic             match;
    logic             wrap_evt;

`ifdef COUNT_CHECKER_RESYNC_EN
    localparam int RUN_W = $clog2(RESYNC_RUN + 1);
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
`endif

    // Value the counter must show now, given what it showed and was told last cycle.
    assign exp_val  = y_prev_q + CNT_W'(w_prev_q);
    assign match    = (y_in == exp_val);
    assign wrap_evt = w_prev_q && (y_prev_q == '1) && (y_in == '0);

    // Next-state and next-output decode; clr overrides any same-cycle event.
    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        wrap_d   = 1'b0;
`ifdef COUNT_CHECKER_RESYNC_EN
        run_d    = '0;
`endif
        if (clr) begin
            state_d  = SYNC;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    if (!match) begin
                        state_d  = ERROR;
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end else if (wrap_evt) begin
                        wrap_d = 1'b1;
                    end
                end
                ERROR: begin
`ifdef COUNT_CHECKER_RESYNC_EN
                    // A mismatch leaves run_d at its zero default.
                    if (match) begin
                        if (run_q == RUN_W'(RESYNC_RUN - 1)) begin
                            state_d = TRACK;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end
`endif
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    // State, history and registered outputs; history keeps sampling in every state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= SYNC;
            y_prev_q <= '0;
            w_prev_q <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            wrap_q   <= 1'b0;
            locked_q <= 1'b0;
`ifdef COUNT_CHECKER_RESYNC_EN
            run_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            y_prev_q <= y_in;
            w_prev_q <= w_in;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            wrap_q   <= wrap_d;
            locked_q <= (state_d == TRACK);
`ifdef COUNT_CHECKER_RESYNC_EN
            run_q    <= run_d;
`endif
        end
    end

    sat_counter #(
        .WRAP_W (WRAP_W)
    ) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wrap_d),
        .q   (wrap_count)
    );

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: a reference model queues expected outputs per step.
// Latency: each step compares outputs 1 time unit after the clock edge that consumed it.
// Backpressure: n/a.
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       w_in;
    logic [2:0] y_in;

    logic       locked, err, err_sticky, wrap;
    logic [7:0] wrap_count;
    logic       locked2, err2, err_sticky2, wrap2;
    logic [1:0] wrap_count2;

    int total = 0;
    int bad   = 0;

    int err_seen   = 0;
    int wrap_seen  = 0;
    int wrap2_seen = 0;

    typedef struct packed {
        logic       err;
        logic       sticky;
        logic       wrap;
        logic       locked;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];

    // Reference model state (0 = SYNC, 1 = TRACK, 2 = ERROR)
    int         m_st;
    logic [2:0] m_yp;
    logic       m_wp;
    logic       m_err, m_sticky, m_wrap, m_locked;
    logic [7:0] m_c8;
    logic [1:0] m_c2;
    int         m_run;

    always #5 clk = ~clk;

    count_checker #(.WRAP_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .w_in       (w_in),
        .y_in       (y_in),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .wrap       (wrap),
        .wrap_count (wrap_count)
    );

    count_checker #(.WRAP_W(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .w_in       (w_in),
        .y_in       (y_in),
        .locked     (locked2),
        .err        (err2),
        .err_sticky (err_sticky2),
        .wrap       (wrap2),
        .wrap_count (wrap_count2)
    );

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic [2:0] y);
        exp_t       e;
        exp_t       got;
        logic [2:0] ex;
        int         nst;
        rst  = r;
        clr  = c;
        w_in = w;
        y_in = y;
        if (!r) begin
            m_st = 0; m_yp = 3'd0; m_wp = 1'b0;
            m_err = 1'b0; m_sticky = 1'b0; m_wrap = 1'b0; m_locked = 1'b0;
            m_c8 = 8'd0; m_c2 = 2'd0; m_run = 0;
        end else begin
            ex     = m_yp + {2'b00, m_wp};
            nst    = m_st;
            m_err  = 1'b0;
            m_wrap = 1'b0;
            if (c) begin
                nst = 0; m_sticky = 1'b0; m_c8 = 8'd0; m_c2 = 2'd0; m_run = 0;
            end else if (m_st == 0) begin
                nst = 1;
            end else if (m_st == 1) begin
                if (y != ex) begin
                    nst = 2; m_err = 1'b1; m_sticky = 1'b1; m_run = 0;
                end else if (m_wp && m_yp == 3'd7 && y == 3'd0) begin
                    m_wrap = 1'b1;
                    if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
                    if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
                end
            end else begin
`ifdef COUNT_CHECKER_RESYNC_EN
                if (y == ex) begin
                    m_run++;
                    if (m_run >= 2) begin
                        nst = 1; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
`endif
            end
            m_st     = nst;
            m_locked = (nst == 1);
            m_yp     = y;
            m_wp     = w;
        end
        e.err = m_err; e.sticky = m_sticky; e.wrap = m_wrap; e.locked = m_locked;
        e.c8 = m_c8; e.c2 = m_c2;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk1("err",        err,         got.err);
        chk1("err_sticky", err_sticky,  got.sticky);
        chk1("wrap",       wrap,        got.wrap);
        chk1("locked",     locked,      got.locked);
        chk8("wrap_count", wrap_count,  got.c8);
        chk1("wrap2",      wrap2,       got.wrap);
        chk1("locked2",    locked2,     got.locked);
        chk8("wrap_count2", {6'b0, wrap_count2}, {6'b0, got.c2});
        if (err)   err_seen++;
        if (wrap)  wrap_seen++;
        if (wrap2) wrap2_seen++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clr = 1'b0; w_in = 1'b0; y_in = 3'd0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0);
        chk1("reset_locked", locked, 1'b0);
        chk8("reset_count", wrap_count, 8'd0);

        // Clean count 0..7,0,1 with enable high
        err_seen = 0; wrap_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'(i));
            if (i == 0) chk1("locked_after_first", locked, 1'b1);
        end
        chk8("clean_wraps", 8'(wrap_seen), 8'd1);
        chk8("clean_errs", 8'(err_seen), 8'd0);
        chk8("clean_count", wrap_count, 8'd1);

        // Mismatch: locked at 3 with w=1, then 5
        step(1'b1, 1'b0, 1'b1, 3'd2);
        step(1'b1, 1'b0, 1'b1, 3'd3);
        err_seen = 0;
        step(1'b1, 1'b0, 1'b1, 3'd5);
        chk1("mm_err", err, 1'b1);
        chk1("mm_sticky", err_sticky, 1'b1);
        chk1("mm_locked", locked, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd6);
        chk1("mm_err_drop", err, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd7);
        chk8("mm_err_pulses", 8'(err_seen), 8'd1);
        chk1("mm_sticky_held", err_sticky, 1'b1);
`ifdef COUNT_CHECKER_RESYNC_EN
        chk1("resync_locked", locked, 1'b1);
`else
        chk1("no_resync_locked", locked, 1'b0);
`endif

        // clr alone, then clr colliding with a mismatch
        step(1'b1, 1'b1, 1'b1, 3'd0);
        chk1("clr_sticky", err_sticky, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd1);
        step(1'b1, 1'b0, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 3'd6);
        chk1("clr_mm_err", err, 1'b0);
        chk1("clr_mm_sticky", err_sticky, 1'b0);
        chk1("clr_mm_locked", locked, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd7);
        chk1("clr_relock", locked, 1'b1);
        step(1'b1, 1'b0, 1'b1, 3'd0);

        // Reset mid-count at 4, then resume from 0
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 3'(i));
        step(1'b0, 1'b0, 1'b1, 3'd5);
        chk1("rst_err", err, 1'b0);
        chk1("rst_sticky", err_sticky, 1'b0);
        chk1("rst_wrap", wrap, 1'b0);
        chk1("rst_lock", locked, 1'b0);
        chk8("rst_cnt", wrap_count, 8'd0);
        err_seen = 0;
        step(1'b1, 1'b0, 1'b1, 3'd0);
        step(1'b1, 1'b0, 1'b1, 3'd1);
        chk8("rst_resume_errs", 8'(err_seen), 8'd0);

        // Hold at 7 with enable low: neither wrap nor mismatch
        for (int i = 2; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 3'(i));
        wrap_seen = 0;
        step(1'b1, 1'b0, 1'b0, 3'd7);
        step(1'b1, 1'b0, 1'b0, 3'd7);
        step(1'b1, 1'b0, 1'b1, 3'd7);
        chk8("hold7_wraps", 8'(wrap_seen), 8'd0);
        step(1'b1, 1'b0, 1'b1, 3'd0);
        chk8("hold7_then_wrap", 8'(wrap_seen), 8'd1);
        chk8("hold7_errs", 8'(err_seen), 8'd0);

        // Saturation: four full cycles on both widths
        step(1'b0, 1'b0, 1'b0, 3'd0);
        wrap_seen = 0; wrap2_seen = 0; err_seen = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 3'(i));
        end
        step(1'b1, 1'b0, 1'b1, 3'd0);
        chk8("sat_wrap2_pulses", 8'(wrap2_seen), 8'd4);
        chk8("sat_count2", {6'b0, wrap_count2}, 8'd3);
        chk8("sat_count8", wrap_count, 8'd4);
        chk8("sat_errs", 8'(err_seen), 8'd0);
        chk8("sb_empty", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
